sec_timer: RTL
==============

SEC_TIMER -- requirements
Module: sec_timer

Interface
REQ-001 SHALL have port clk  input  1  system clock (50 MHz); all state updates on its rising edge.
REQ-002 SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port clk_1Hz  input  1  1 Hz square wave from the upstream frequency divider; asynchronous to this block's logic.
REQ-004 SHALL have port start_stop  input  1  one-clk-cycle pulse; toggles run state.
REQ-005 SHALL have port clear  input  1  synchronous clear of the time digits, active-high.
REQ-006 SHALL have port sec_lo  output  4  seconds units, BCD 0-9.
REQ-007 SHALL have port sec_hi  output  4  seconds tens, BCD 0-5.
REQ-008 SHALL have port min_lo  output  4  minutes units, BCD 0-9.
REQ-009 SHALL have port min_hi  output  4  minutes tens, BCD 0-5.
REQ-010 SHALL have port running  output  1  1 = RUN state, 0 = STOP state.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover.

Function
REQ-012 SHALL synchronise clk_1Hz through registers s1 -> s2, then register s3 <= s2.
REQ-013 SHALL form tick = s2 AND NOT s3: exactly one clk cycle per clk_1Hz rising edge.
- Latency: clk_1Hz rises before edge k; s1 = 1 after edge k; tick high between edges k+1 and k+2; digits update at edge k+2.
REQ-014 SHALL implement a two-state run FSM: STOP (reset state) and RUN.
- start_stop = 1: STOP -> RUN and RUN -> STOP on the same edge.
- Otherwise the state holds.
REQ-015 SHALL drive running = 1 exactly while the FSM is in RUN.
REQ-016 SHALL advance the time by one second on each tick that arrives while in RUN; a tick in STOP is discarded, not queued.
REQ-017 SHALL use a cascaded BCD carry chain:
- sec_lo 9 -> 0 with carry into sec_hi.
- sec_hi 5 -> 0 with carry into min_lo.
- min_lo 9 -> 0 with carry into min_hi.
- min_hi 5 -> 0 with carry out.
REQ-018 SHALL, at 59:59 with an accepted tick, load 00:00 and assert wrap for exactly that following cycle; wrap is 0 at all other times.
REQ-019 SHALL, on clear = 1, load 00:00 on that edge regardless of tick.
- Clear has priority over increment.
- Clear does not change the run state.
- Clear never asserts wrap.
REQ-020 SHALL, when start_stop and tick coincide, decide the increment from the run state before that edge.
- RUN + start_stop + tick: the count increments and the FSM goes to STOP.
- STOP + start_stop + tick: no increment and the FSM goes to RUN.
REQ-021 SHALL never present a non-BCD value or a tens digit above 5 on any digit output.
REQ-022 SHALL tolerate any clk_1Hz period of at least 4 clk cycles without losing a tick; the divider's divide-by-4 test setting meets this.

Reset
REQ-023 SHALL, while clr_n = 0, asynchronously force these values:
- s1, s2, s3 = 0.
- FSM = STOP, running = 0.
- All four digits = 0, wrap = 0.
REQ-024 SHALL, on clr_n assertion mid-count or mid-tick, abandon the count with no partial increment; after release, the first tick requires a fresh 0 -> 1 edge seen at s2/s3.

Verification
REQ-025 SHALL cover these directed scenarios:
- V1: reset, start_stop pulse, clk_1Hz period 4 clk for 10 rising edges -> running = 1, time = 00:10, tick width 1 cycle each, update at edge k+2.
- V2: preset by counting to 00:59, one more tick -> 01:00; count to 59:59, one more tick -> 00:00 with wrap = 1 for one cycle only.
- V3: running at 00:05, start_stop pulse, 3 ticks -> running = 0, time stays 00:05; second start_stop pulse then 1 tick -> 00:06.
- V4: clear asserted on the same cycle as tick at 00:07 -> 00:00 next edge, no increment, running unchanged, wrap = 0.
- V5: start_stop coincident with tick in RUN at 00:03 -> 00:04, running = 0; coincident again in STOP -> stays 00:04, running = 1.
- V6: clr_n pulsed low asynchronously between clk edges at 12:34 while clk_1Hz = 1 -> outputs 00:00, STOP immediately; no tick until clk_1Hz falls and rises again.

Source files
------------

// File: rtl/sec_timer.sv
// MM:SS stopwatch: counts seconds from a synchronised 1 Hz strobe while in RUN,
// with a start/stop toggle, synchronous digit clear and a 59:59 rollover pulse.
module sec_timer (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       clk_1Hz,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       wrap,
  output logic       fsm_state
);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  run_state_t state;

  logic s1;
  logic s2;
  logic s3;
  logic tick;
  logic inc;
  logic carry_sec_lo;
  logic carry_sec_hi;
  logic carry_min_lo;
  logic carry_min_hi;

  // s1/s2 form the two-flop synchroniser; s3 delays s2 for rising-edge detection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_1Hz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Increment is judged on the state before this edge, so a start_stop
  // arriving with the tick does not affect whether that tick counts.
  assign inc = tick && (state == RUN);

  // Digit wrap tests use >= so an out-of-range digit can only ever fall back to 0.
  assign carry_sec_lo = inc          && (sec_lo >= 4'd9);
  assign carry_sec_hi = carry_sec_lo && (sec_hi >= 4'd5);
  assign carry_min_lo = carry_sec_hi && (min_lo >= 4'd9);
  assign carry_min_hi = carry_min_lo && (min_hi >= 4'd5);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= STOP;
      running <= 1'b0;
    end else if (start_stop) begin
      state   <= (state == RUN) ? STOP : RUN;
      running <= (state == STOP);
    end
  end

  assign fsm_state = state;

  // Clear wins over increment and never produces a wrap pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sec_lo <= 4'd0;
      sec_hi <= 4'd0;
      min_lo <= 4'd0;
      min_hi <= 4'd0;
      wrap   <= 1'b0;
    end else if (clear) begin
      sec_lo <= 4'd0;
      sec_hi <= 4'd0;
      min_lo <= 4'd0;
      min_hi <= 4'd0;
      wrap   <= 1'b0;
    end else begin
      wrap <= carry_min_hi;
      if (inc) begin
        sec_lo <= carry_sec_lo ? 4'd0 : sec_lo + 4'd1;
      end
      if (carry_sec_lo) begin
        sec_hi <= carry_sec_hi ? 4'd0 : sec_hi + 4'd1;
      end
      if (carry_sec_hi) begin
        min_lo <= carry_min_lo ? 4'd0 : min_lo + 4'd1;
      end
      if (carry_min_lo) begin
        min_hi <= carry_min_hi ? 4'd0 : min_hi + 4'd1;
      end
    end
  end

endmodule
